// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: tag/data lookup, read-miss fill from memory,
// write-through with no write allocate. Arrays are external and write on negedge.
module dm_cache_ctrl #(
   parameter  int ADDR_W = 16,
   parameter  int IDX_W  = 4,
   parameter  int DATA_W = 16,
   localparam int TAG_W  = ADDR_W - IDX_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cpuReq,
   input  logic              cpuWe,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWData,
   output logic [DATA_W-1:0] cpuRData,
   output logic              cpuDone,
   output logic [IDX_W-1:0]  arrAddr,
   input  logic [TAG_W:0]    tagRd,
   output logic [TAG_W:0]    tagWr,
   output logic              tagWe,
   input  logic [DATA_W-1:0] dataRd,
   output logic [DATA_W-1:0] dataWr,
   output logic              dataWe,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memRData
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MEMRD,
      S_FILL,
      S_MEMWR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   fill_q, fill_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                done_q, done_d;
   logic [TAG_W-1:0]    tag;
   logic                hit;

   assign tag      = addr_q[ADDR_W-1:IDX_W];
   assign hit      = tagRd[TAG_W] && (tagRd[TAG_W-1:0] == tag);
   assign arrAddr  = addr_q[IDX_W-1:0];
   assign tagWr    = {1'b1, tag};
   assign memAddr  = addr_q;
   assign memWData = wdata_q;
   assign cpuRData = rdata_q;
   assign cpuDone  = done_q;

   // Enables decode from the state register only, so they hold across the negedge write.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      fill_d  = fill_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      tagWe   = 1'b0;
      dataWe  = 1'b0;
      dataWr  = wdata_q;
      memReq  = 1'b0;
      memWe   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpuReq) begin
               addr_d  = cpuAddr;
               we_d    = cpuWe;
               wdata_d = cpuWData;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (we_q) begin
               dataWe  = hit;
               state_d = S_MEMWR;
            end else if (hit) begin
               rdata_d = dataRd;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMRD: begin
            memReq = 1'b1;
            if (memAck) begin
               fill_d  = memRData;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            tagWe   = 1'b1;
            dataWe  = 1'b1;
            dataWr  = fill_q;
            rdata_d = fill_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_MEMWR: begin
            memReq = 1'b1;
            memWe  = 1'b1;
            if (memAck) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         fill_q  <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         fill_q  <= fill_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with behavioural tag/data arrays and a
// hand-driven memory acknowledge.
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic        cpuReq, cpuWe;
   logic [15:0] cpuAddr, cpuWData, cpuRData;
   logic        cpuDone;
   logic [3:0]  arrAddr;
   logic [12:0] tagRd, tagWr;
   logic        tagWe;
   logic [15:0] dataRd, dataWr;
   logic        dataWe;
   logic        memReq, memWe;
   logic [15:0] memAddr, memWData;
   logic        memAck;
   logic [15:0] memRData;

   logic [12:0] tag_arr  [16];
   logic [15:0] data_arr [16];
   int          tag_wr_cnt  = 0;
   int          data_wr_cnt = 0;
   int          total = 0;
   int          bad   = 0;
   int          tw0, dw0;

   always #5 clk = ~clk;

   dm_cache_ctrl dut (
      .clk(clk), .clr(clr),
      .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
      .cpuRData(cpuRData), .cpuDone(cpuDone),
      .arrAddr(arrAddr), .tagRd(tagRd), .tagWr(tagWr), .tagWe(tagWe),
      .dataRd(dataRd), .dataWr(dataWr), .dataWe(dataWe),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memAck(memAck), .memRData(memRData)
   );

   assign tagRd  = tag_arr[arrAddr];
   assign dataRd = data_arr[arrAddr];

   // External register arrays: combinational read, falling-edge write, cleared by clr.
   always @(negedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 16; i++) begin
            tag_arr[i]  <= '0;
            data_arr[i] <= '0;
         end
      end else begin
         if (tagWe) begin
            tag_arr[arrAddr] <= tagWr;
            tag_wr_cnt       <= tag_wr_cnt + 1;
         end
         if (dataWe) begin
            data_arr[arrAddr] <= dataWr;
            data_wr_cnt       <= data_wr_cnt + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one request in IDLE; returns in the LOOKUP cycle.
   task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
      cpuReq   = 1'b1;
      cpuWe    = we;
      cpuAddr  = addr;
      cpuWData = wd;
      tick();
      cpuReq   = 1'b0;
      cpuAddr  = 16'h0;
      cpuWData = 16'h0;
   endtask

   initial begin
      clr = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
      memAck = 1'b0; memRData = '0;
      tick(); tick();
      chk("rst_done", cpuDone, 0);
      chk("rst_rdata", cpuRData, 0);
      chk("rst_memreq", memReq, 0);
      chk("rst_memwe", memWe, 0);
      chk("rst_tagwe", tagWe, 0);
      chk("rst_datawe", dataWe, 0);
      clr = 1'b1;
      tick();

      // Read miss 0x1234, ack in cycle 2
      issue(1'b0, 16'h1234, 16'h0);
      chk("m1_lk_arraddr", arrAddr, 4);
      chk("m1_lk_memreq", memReq, 0);
      chk("m1_lk_tagwe", tagWe, 0);
      tick();
      chk("m1_rd_memreq", memReq, 1);
      chk("m1_rd_memwe", memWe, 0);
      chk("m1_rd_memaddr", memAddr, 16'h1234);
      memAck = 1'b1; memRData = 16'hBEEF;
      tick();
      memAck = 1'b0; memRData = 16'h0;
      chk("m1_fill_memreq", memReq, 0);
      chk("m1_fill_tagwe", tagWe, 1);
      chk("m1_fill_datawe", dataWe, 1);
      chk("m1_fill_tagwr", tagWr, 13'h1123);
      chk("m1_fill_datawr", dataWr, 16'hBEEF);
      chk("m1_fill_done", cpuDone, 0);
      tick();
      chk("m1_done", cpuDone, 1);
      chk("m1_rdata", cpuRData, 16'hBEEF);
      chk("m1_tagarr", tag_arr[4], 13'h1123);
      chk("m1_dataarr", data_arr[4], 16'hBEEF);
      chk("m1_idle_tagwe", tagWe, 0);

      // Back-to-back read hit 0x1234, accepted in the cpuDone cycle
      issue(1'b0, 16'h1234, 16'h0);
      chk("h1_lk_done", cpuDone, 0);
      chk("h1_lk_datawe", dataWe, 0);
      tick();
      chk("h1_done", cpuDone, 1);
      chk("h1_rdata", cpuRData, 16'hBEEF);
      chk("h1_memreq", memReq, 0);
      tick();
      chk("h1_done_pulse", cpuDone, 0);

      // Read 0x5674: same index, different tag -> replace
      issue(1'b0, 16'h5674, 16'h0);
      tick();
      chk("m2_rd_memreq", memReq, 1);
      chk("m2_rd_memaddr", memAddr, 16'h5674);
      memAck = 1'b1; memRData = 16'h1111;
      tick();
      memAck = 1'b0;
      chk("m2_fill_tagwr", tagWr, 13'h1567);
      tick();
      chk("m2_done", cpuDone, 1);
      chk("m2_rdata", cpuRData, 16'h1111);
      chk("m2_tagarr", tag_arr[4], 13'h1567);
      tick();

      // Write hit 0xCAFE to 0x5674
      tw0 = tag_wr_cnt;
      issue(1'b1, 16'h5674, 16'hCAFE);
      chk("wh_lk_datawe", dataWe, 1);
      chk("wh_lk_tagwe", tagWe, 0);
      chk("wh_lk_datawr", dataWr, 16'hCAFE);
      chk("wh_lk_memreq", memReq, 0);
      tick();
      chk("wh_wr_memreq", memReq, 1);
      chk("wh_wr_memwe", memWe, 1);
      chk("wh_wr_memaddr", memAddr, 16'h5674);
      chk("wh_wr_memwdata", memWData, 16'hCAFE);
      chk("wh_wr_datawe", dataWe, 0);
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      chk("wh_done", cpuDone, 1);
      chk("wh_rdata_kept", cpuRData, 16'h1111);
      chk("wh_memreq_low", memReq, 0);
      chk("wh_dataarr", data_arr[4], 16'hCAFE);
      chk("wh_no_tagwr", tag_wr_cnt, tw0);
      tick();

      // Read 0x5674 now hits with the written word
      issue(1'b0, 16'h5674, 16'h0);
      chk("h2_lk_memreq", memReq, 0);
      tick();
      chk("h2_done", cpuDone, 1);
      chk("h2_rdata", cpuRData, 16'hCAFE);
      tick();

      // Write miss 0x0001 to 0x9990: memory only
      tw0 = tag_wr_cnt; dw0 = data_wr_cnt;
      issue(1'b1, 16'h9990, 16'h0001);
      chk("wm_lk_datawe", dataWe, 0);
      chk("wm_lk_tagwe", tagWe, 0);
      tick();
      chk("wm_wr_memreq", memReq, 1);
      chk("wm_wr_memwe", memWe, 1);
      chk("wm_wr_memaddr", memAddr, 16'h9990);
      chk("wm_wr_memwdata", memWData, 16'h0001);
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      chk("wm_done", cpuDone, 1);
      chk("wm_no_tagwr", tag_wr_cnt, tw0);
      chk("wm_no_datawr", data_wr_cnt, dw0);
      chk("wm_tagarr0", tag_arr[0], 13'h0);

      // memAck while idle is ignored
      memAck = 1'b1;
      tick();
      chk("ia_memreq", memReq, 0);
      chk("ia_done", cpuDone, 0);
      tick();
      memAck = 1'b0;
      chk("ia_memreq2", memReq, 0);
      chk("ia_tagwe", tagWe, 0);
      tick();
      chk("ia_memreq3", memReq, 0);

      // Read 0x1234 misses again (evicted); ack delayed 5 cycles
      issue(1'b0, 16'h1234, 16'h0);
      chk("m3_lk_memreq", memReq, 0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("m3_wait%0d_memreq", c), memReq, 1);
         chk($sformatf("m3_wait%0d_memwe", c), memWe, 0);
         chk($sformatf("m3_wait%0d_memaddr", c), memAddr, 16'h1234);
         chk($sformatf("m3_wait%0d_tagwe", c), tagWe, 0);
      end
      tick();
      chk("m3_ack_memreq", memReq, 1);
      memAck = 1'b1; memRData = 16'h7777;
      tick();
      memAck = 1'b0;
      chk("m3_fill_memreq", memReq, 0);
      chk("m3_fill_datawr", dataWr, 16'h7777);
      tick();
      chk("m3_done", cpuDone, 1);
      chk("m3_rdata", cpuRData, 16'h7777);
      chk("m3_tagarr", tag_arr[4], 13'h1123);
      tick();

      // Reset in the middle of MEMRD
      issue(1'b0, 16'h00A5, 16'h0);
      tick();
      chk("rm_rd_memreq", memReq, 1);
      chk("rm_rd_memaddr", memAddr, 16'h00A5);
      tw0 = tag_wr_cnt; dw0 = data_wr_cnt;
      clr = 1'b0;
      #1;
      chk("rm_async_memreq", memReq, 0);
      chk("rm_async_tagwe", tagWe, 0);
      memAck = 1'b1; memRData = 16'hDEAD;
      tick();
      memAck = 1'b0;
      tick();
      chk("rm_no_tagwr", tag_wr_cnt, tw0);
      chk("rm_no_datawr", data_wr_cnt, dw0);
      chk("rm_done", cpuDone, 0);
      clr = 1'b1;
      tick();
      chk("rm_after_memreq", memReq, 0);

      issue(1'b0, 16'h1234, 16'h0);
      chk("rm_lk_memreq", memReq, 0);
      tick();
      chk("rm_new_memreq", memReq, 1);
      chk("rm_new_memaddr", memAddr, 16'h1234);
      memAck = 1'b1; memRData = 16'h4242;
      tick();
      memAck = 1'b0;
      chk("rm_new_tagwe", tagWe, 1);
      tick();
      chk("rm_new_done", cpuDone, 1);
      chk("rm_new_rdata", cpuRData, 16'h4242);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Controller for the direct-mapped cache: accepts single-word CPU read/write requests, splits the address into index and tag, and looks up the tag array and data array. Both arrays are external register-array instances that read combinationally and write on the falling clock edge. Read misses are filled from main memory over a request/acknowledge handshake. Writes are write-through and no-write-allocate.

## Interface
- ADDR_W, 16, word address width
- IDX_W, 4, index width (array depth 2**IDX_W)
- DATA_W, 16, data word width
- TAG_W = ADDR_W-IDX_W (12), derived, not overridable; tag-array entry width TAG_W+1 = {valid, tag}
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-low
- cpuReq  in  1  request strobe, sampled only in IDLE
- cpuWe  in  1  1 = write, 0 = read; qualified by cpuReq
- cpuAddr  in  ADDR_W  word address; index = [IDX_W-1:0], tag = [ADDR_W-1:IDX_W]
- cpuWData  in  DATA_W  write data
- cpuRData  out  DATA_W  read data, valid while cpuDone=1
- cpuDone  out  1  one-cycle completion pulse
- arrAddr  out  IDX_W  read and write address for both arrays
- tagRd  in  TAG_W+1  tag-array read data
- tagWr  out  TAG_W+1  tag-array write data
- tagWe  out  1  tag-array write enable
- dataRd  in  DATA_W  data-array read data
- dataWr  out  DATA_W  data-array write data
- dataWe  out  1  data-array write enable
- memReq  out  1  memory request
- memWe  out  1  memory write
- memAddr  out  ADDR_W  memory word address
- memWData  out  DATA_W  memory write data
- memAck  in  1  memory acknowledge, one cycle
- memRData  in  DATA_W  memory read data, valid with memAck

## Operation
- States: IDLE, LOOKUP, MEMRD, FILL, MEMWR.
- **IDLE**
  - cpuReq=1 latches cpuAddr, cpuWe and cpuWData into internal registers, then moves to LOOKUP.
  - cpuReq is ignored in every other state. The CPU must not issue a new request before cpuDone.
- **LOOKUP**
  - arrAddr = latched index; arrAddr holds this value through FILL.
  - hit = tagRd[TAG_W] & (tagRd[TAG_W-1:0] == latched tag).
  - Read hit: cpuRData <= dataRd, cpuDone <= 1, next state IDLE.
  - Read miss: next state MEMRD.
  - Write hit: dataWe=1 and dataWr = latched wdata during this cycle, then MEMWR.
  - Write miss: no array write, then MEMWR.
- **MEMRD**
  - memReq=1, memWe=0, memAddr = latched address.
  - On memAck=1: capture memRData into the fill register, move to FILL.
- **FILL**
  - tagWe = dataWe = 1 for exactly this cycle.
  - tagWr = {1'b1, tag}; dataWr = fill register.
  - cpuRData <= fill register, cpuDone <= 1, next state IDLE.
- **MEMWR**
  - memReq=1, memWe=1, memAddr and memWData = latched values.
  - On memAck=1: cpuDone <= 1, next state IDLE. cpuRData is unchanged.
- **Memory outputs**
  - memAddr, memWData and memWe are stable for the whole time memReq=1.
  - memReq falls in the cycle after memAck is sampled.
  - memAck while memReq=0 is ignored.
  - There is no timeout: an ack that never arrives keeps the controller in MEMRD or MEMWR indefinitely.
- **Array enables**
  - tagWe and dataWe are never asserted outside LOOKUP (dataWe on write hit only) and FILL.
  - tagWe is never asserted on a write.
- **Invalidation**: the arrays are cleared by the same clr. The controller issues no invalidations of its own.

## Timing
- Reset (clr=0, asynchronous)
  - state = IDLE.
  - cpuDone, cpuRData, memReq, memWe, tagWe and dataWe = 0; all latched registers = 0.
  - Takes effect immediately, including mid-transaction: memReq drops without waiting for memAck, and no array write occurs.
- cpuDone is registered and asserted for exactly one cycle, the first IDLE cycle after completion. A new cpuReq is accepted in that same cycle (back-to-back).
- The arrays write on the falling edge inside the cycle in which tagWe/dataWe are high. The enables are driven from state registers so that they are stable across that edge.
- Latency, counting from the cpuReq cycle as cycle 0:
  - Read hit: cpuDone in cycle 2.
  - Read miss with memAck in cycle k (k >= 2): FILL in cycle k+1, cpuDone in cycle k+2.
  - Write with memAck in cycle k: cpuDone in cycle k+1.
- Zero-wait memory (memAck in the first MEMRD/MEMWR cycle) is legal.

## Test plan
- After reset (arrays clear), read 0x1234 -> MEMRD with memAddr=0x1234; ack with memRData=0xBEEF -> FILL writes tag entry {1,0x123} at index 4 and data 0xBEEF; cpuDone with cpuRData=0xBEEF.
- Repeat read 0x1234 -> no memReq; cpuDone in cycle 2 with cpuRData=0xBEEF.
- Read 0x5674 (same index 4, different tag) -> miss; ack 0x1111 -> entry replaced with {1,0x567}; a subsequent read of 0x1234 misses again.
- Write 0xCAFE to 0x5674 (hit) -> dataWe in LOOKUP, memReq/memWe=1 with memWData=0xCAFE; after ack, reading 0x5674 hits and returns 0xCAFE. Write 0x0001 to 0x9990 (miss) -> memory write only, tagWe and dataWe stay 0.
- Delay memAck by 5 cycles on a read miss -> memReq, memAddr and memWe stable for all 5 cycles, memReq drops after ack; pulse memAck while in IDLE -> no effect.
- Assert clr=0 mid-MEMRD -> memReq=0 immediately, no FILL writes; after release, the controller is in IDLE and accepts a new request.
